ms_out_collector: RTL



---
 rtl/ms_out_collector_pkg.sv | 36 +++
 rtl/ms_flow_fifo.sv | 71 +++++++
 rtl/ms_out_collector.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/ms_out_collector_pkg.sv
// ms_out_collector_pkg
// Shared types and helpers for the multi-stream output collector.
//   flow_state_e   : per-flow lifecycle (IDLE -> ACTIVE -> DONE)
//   DEFAULT_DEPTH  : default per-flow FIFO depth
//   DEFAULT_CNT_W  : default per-flow sample-count width
//   get_tag        : pulls the flow tag out of a {tag, payload} word
//   tag_in_range   : true when a decoded tag names an existing flow
// Optional feature macro used by the top level: MS_OUT_COLLECTOR_STATS_EN

package ms_out_collector_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } flow_state_e;

    localparam int DEFAULT_DEPTH = 16;
    localparam int DEFAULT_CNT_W = 13;

    // The caller zero-extends its tagged word to 64 bits; the tag sits
    // directly above the payload, so shift the payload away and mask.
    function automatic logic [31:0] get_tag(input logic [63:0] word,
                                            input int          lsb,
                                            input int          width);
        logic [63:0] mask;
        mask = (64'd1 << width) - 64'd1;
        return 32'((word >> lsb) & mask);
    endfunction

    function automatic logic tag_in_range(input logic [31:0] tag,
                                          input int          flux);
        return tag < 32'(flux);
    endfunction

endpackage

// File: rtl/ms_flow_fifo.sv
// ms_flow_fifo
// Single-flow synchronous FIFO with registered read data.
//   clk, rst   : clock, synchronous active-high reset
//   push, din  : write request and data (ignored while full)
//   pop, dout  : read request (ignored while empty); dout updates the
//                cycle after the pop edge and holds otherwise
//   flush      : drops all contents by resetting pointers and occupancy
//   occupancy  : number of stored entries, 0..DEPTH
//   empty      : occupancy == 0

module ms_flow_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [DATA_W-1:0]        din,
    output logic [DATA_W-1:0]        dout,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    // Guard against overflow/underflow locally so the FIFO is safe even
    // if the caller's gating is ever loosened.
    assign do_push = push && (occupancy != OCC_W'(DEPTH));
    assign do_pop  = pop && (occupancy != '0);
    assign empty   = (occupancy == '0);

    // Storage array has no reset; only pointers define validity.
    always_ff @(posedge clk) begin
        if (!rst && !flush && do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
            dout      <= '0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                dout   <= mem[rd_ptr];
            end
            occupancy <= occupancy + OCC_W'(do_push) - OCC_W'(do_pop);
        end
    end

endmodule

// File: rtl/ms_out_collector.sv
// ms_out_collector
// Output-side receiver for the multi-stream interpolation accelerator.
// Splits one tagged write stream into per-flow FIFOs, applies per-flow
// back-pressure and tracks each flow's completion against a configured
// sample count.
//   clk, rst   : single clock, synchronous active-high reset
//   in_din     : {tag, data} sample; in_write qualifies it
//   in_full    : per-flow registered back-pressure
//   cfg_din    : {tag, expected count}; cfg_write qualifies it
//   out_read   : per-flow pop request
//   out_dout   : per-flow registered read data, flow 0 in the LSBs
//   out_empty  : per-flow FIFO empty
//   done       : flow has delivered its configured count
//   err        : one-cycle pulse after any dropped sample
// Optional feature: define MS_OUT_COLLECTOR_STATS_EN to add t_first and
// t_end (per-flow cycle stamps of first push and final pop).

module ms_out_collector
    import ms_out_collector_pkg::*;
#(
    parameter int FLUX   = 2,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int DATA_W = 8,
    parameter int TAG_W  = (FLUX > 1) ? $clog2(FLUX) : 1,
    parameter int CNT_W  = DEFAULT_CNT_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [TAG_W+DATA_W-1:0]   in_din,
    input  logic                      in_write,
    output logic [FLUX-1:0]           in_full,
    input  logic [TAG_W+CNT_W-1:0]    cfg_din,
    input  logic                      cfg_write,
    input  logic [FLUX-1:0]           out_read,
    output logic [FLUX*DATA_W-1:0]    out_dout,
    output logic [FLUX-1:0]           out_empty,
    output logic [FLUX-1:0]           done,
    output logic                      err
`ifdef MS_OUT_COLLECTOR_STATS_EN
    ,
    output logic [FLUX*(CNT_W+8)-1:0] t_first,
    output logic [FLUX*(CNT_W+8)-1:0] t_end
`endif
);

    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic [31:0]       in_tag;
    logic              in_tag_ok;
    logic [DATA_W-1:0] in_data;
    logic [31:0]       cfg_tag;
    logic              cfg_tag_ok;
    logic [CNT_W-1:0]  cfg_count;

    flow_state_e       state       [FLUX];
    flow_state_e       state_nx    [FLUX];
    logic [CNT_W-1:0]  expected    [FLUX];
    logic [CNT_W-1:0]  expected_nx [FLUX];
    logic [CNT_W-1:0]  wr_cnt      [FLUX];
    logic [CNT_W-1:0]  wr_cnt_nx   [FLUX];
    logic [CNT_W-1:0]  rd_cnt      [FLUX];
    logic [CNT_W-1:0]  rd_cnt_nx   [FLUX];

    logic [FLUX-1:0][OCC_W-1:0] occ;
    logic [FLUX-1:0][OCC_W-1:0] occ_nx;

    logic [FLUX-1:0]   cfg_hit;
    logic [FLUX-1:0]   push;
    logic [FLUX-1:0]   pop;
    logic [FLUX-1:0]   finish;
    logic [FLUX-1:0]   full_nx;
    logic              err_nx;

    // Tag decode for both tagged ports.
    assign in_tag     = get_tag(64'(in_din), DATA_W, TAG_W);
    assign in_tag_ok  = tag_in_range(in_tag, FLUX);
    assign in_data    = in_din[DATA_W-1:0];
    assign cfg_tag    = get_tag(64'(cfg_din), CNT_W, TAG_W);
    assign cfg_tag_ok = tag_in_range(cfg_tag, FLUX);
    assign cfg_count  = cfg_din[CNT_W-1:0];

    // Per-flow next-state, counter and back-pressure computation.
    // in_full is registered from the next-cycle view of state, counters
    // and occupancy so it always describes the state it sits beside.
    // A config on a flow overrides any push or pop to it in that cycle.
    always_comb begin
        cfg_hit = '0;
        push    = '0;
        pop     = '0;
        finish  = '0;
        full_nx = '0;
        occ_nx  = occ;
        err_nx  = 1'b0;
        for (int f = 0; f < FLUX; f++) begin
            state_nx[f]    = state[f];
            expected_nx[f] = expected[f];
            wr_cnt_nx[f]   = wr_cnt[f];
            rd_cnt_nx[f]   = rd_cnt[f];
        end
        for (int f = 0; f < FLUX; f++) begin
            cfg_hit[f] = cfg_write && cfg_tag_ok && (cfg_tag == 32'(f));
            push[f]    = in_write && in_tag_ok && (in_tag == 32'(f))
                         && !cfg_hit[f] && (state[f] == ACTIVE)
                         && !in_full[f] && (wr_cnt[f] < expected[f]);
            pop[f]     = out_read[f] && !out_empty[f] && !cfg_hit[f];
            finish[f]  = pop[f] && (state[f] == ACTIVE)
                         && ((rd_cnt[f] + CNT_W'(1)) == expected[f]);

            if (cfg_hit[f]) begin
                expected_nx[f] = cfg_count;
                wr_cnt_nx[f]   = '0;
                rd_cnt_nx[f]   = '0;
                state_nx[f]    = (cfg_count == '0) ? DONE : ACTIVE;
                occ_nx[f]      = '0;
            end else begin
                if (push[f]) begin
                    wr_cnt_nx[f] = wr_cnt[f] + CNT_W'(1);
                end
                if (pop[f]) begin
                    rd_cnt_nx[f] = rd_cnt[f] + CNT_W'(1);
                end
                if (finish[f]) begin
                    state_nx[f] = DONE;
                end
                occ_nx[f] = occ[f] + OCC_W'(push[f]) - OCC_W'(pop[f]);
            end

            full_nx[f] = (occ_nx[f] == OCC_W'(DEPTH))
                         || (state_nx[f] != ACTIVE)
                         || (wr_cnt_nx[f] == expected_nx[f]);
        end
        // Any offered sample that was not pushed somewhere was dropped.
        err_nx = in_write && (push == '0);
    end

    // State and counter registers; reset discards all configuration.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int f = 0; f < FLUX; f++) begin
                state[f]    <= IDLE;
                expected[f] <= '0;
                wr_cnt[f]   <= '0;
                rd_cnt[f]   <= '0;
            end
            in_full <= '1;
            err     <= 1'b0;
        end else begin
            for (int f = 0; f < FLUX; f++) begin
                state[f]    <= state_nx[f];
                expected[f] <= expected_nx[f];
                wr_cnt[f]   <= wr_cnt_nx[f];
                rd_cnt[f]   <= rd_cnt_nx[f];
            end
            in_full <= full_nx;
            err     <= err_nx;
        end
    end

    // done reflects the registered state, so it rises the cycle after
    // the final pop edge.
    always_comb begin
        done = '0;
        for (int f = 0; f < FLUX; f++) begin
            done[f] = (state[f] == DONE);
        end
    end

    // One FIFO per flow; a config on the flow flushes it.
    for (genvar g = 0; g < FLUX; g++) begin : g_flow
        ms_flow_fifo #(
            .DEPTH  (DEPTH),
            .DATA_W (DATA_W)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (push[g]),
            .pop       (pop[g]),
            .flush     (cfg_hit[g]),
            .din       (in_data),
            .dout      (out_dout[g*DATA_W +: DATA_W]),
            .occupancy (occ[g]),
            .empty     (out_empty[g])
        );
    end

`ifdef MS_OUT_COLLECTOR_STATS_EN
    localparam int STAT_W = CNT_W + 8;

    logic [STAT_W-1:0] cycle_cnt;
    logic [FLUX-1:0]   first_seen;

    // Free-running timestamp base.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + STAT_W'(1);
        end
    end

    // Each stamp is taken once per configuration; first_seen latches so
    // later pushes do not overwrite t_first, and the final pop happens
    // only once before DONE.
    for (genvar g = 0; g < FLUX; g++) begin : g_stats
        always_ff @(posedge clk) begin
            if (rst || cfg_hit[g]) begin
                first_seen[g]                  <= 1'b0;
                t_first[g*STAT_W +: STAT_W]    <= '0;
                t_end[g*STAT_W +: STAT_W]      <= '0;
            end else begin
                if (push[g] && !first_seen[g]) begin
                    first_seen[g]               <= 1'b1;
                    t_first[g*STAT_W +: STAT_W] <= cycle_cnt;
                end
                if (finish[g]) begin
                    t_end[g*STAT_W +: STAT_W]   <= cycle_cnt;
                end
            end
        end
    end
`endif

endmodule
